// File: rtl/db_ram_arb_ctrl_if.sv
// Request/response and RAM-side bus of the arbitrated RAM controller.
// Signal names follow the controller's port list; direction suffixes are seen from the controller.
interface db_ram_arb_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 17
);
    logic                  clr_i;
    logic                  clr_done_o;
    logic                  wr_val_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [WORD_WIDTH-1:0] wr_dat_i;
    logic                  wr_rdy_o;
    logic                  rd_req_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic                  rd_gnt_o;
    logic                  rd_val_o;
    logic [WORD_WIDTH-1:0] rd_dat_o;
    logic                  ram_cen_o;
    logic                  ram_oen_o;
    logic                  ram_wen_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [WORD_WIDTH-1:0] ram_dat_o;
    logic [WORD_WIDTH-1:0] ram_dat_i;

    modport master (
        output clr_i, wr_val_i, wr_addr_i, wr_dat_i, rd_req_i, rd_addr_i, ram_dat_i,
        input  clr_done_o, wr_rdy_o, rd_gnt_o, rd_val_o, rd_dat_o,
               ram_cen_o, ram_oen_o, ram_wen_o, ram_addr_o, ram_dat_o
    );

    modport slave (
        input  clr_i, wr_val_i, wr_addr_i, wr_dat_i, rd_req_i, rd_addr_i, ram_dat_i,
        output clr_done_o, wr_rdy_o, rd_gnt_o, rd_val_o, rd_dat_o,
               ram_cen_o, ram_oen_o, ram_wen_o, ram_addr_o, ram_dat_o
    );
endinterface

// File: rtl/db_ram_arb_ctrl.sv
// Single-port RAM controller: zero sweep after reset/clear, then read-priority
// arbitration with a starvation limit that forces a pending write through.
module db_ram_arb_ctrl #(
    parameter int ADDR_WIDTH   = 8,
    parameter int WORD_WIDTH   = 17,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    db_ram_arb_ctrl_if.slave     bus
);
    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [2:0]            LIMIT = 3'(STARVE_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] LAST  = '1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [2:0]            r_starve;
    logic [2:0]            w_starve_nxt;
    logic                  r_rd_val;
    logic                  w_starved;
    logic                  w_wr_rdy;
    logic                  w_rd_gnt;
    logic                  w_cen;
    logic                  w_wen;
    logic                  w_clr_done;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [WORD_WIDTH-1:0] w_dat;

    assign w_starved = (r_starve >= LIMIT);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        w_state_nxt  = r_state;
        w_starve_nxt = '0;
        w_wr_rdy     = 1'b0;
        w_rd_gnt     = 1'b0;
        w_cen        = 1'b1;
        w_wen        = 1'b1;
        w_clr_done   = 1'b0;
        w_addr       = '0;
        w_dat        = '0;
        // NOTE: the RAM strobes are gated by rstn so the RAM sits idle while reset is held,
        // yet the first sweep write lands on the very first edge after release.
        if (rstn) begin
            case (r_state)
                CLEAR: begin
                    w_cen  = 1'b0;
                    w_wen  = 1'b0;
                    w_addr = r_clr_cnt;
                    if (r_clr_cnt == LAST) begin
                        w_clr_done  = 1'b1;
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (bus.clr_i) w_state_nxt = CLEAR;
                    if (bus.rd_req_i && !w_starved) begin
                        w_rd_gnt = 1'b1;
                        w_cen    = 1'b0;
                        w_addr   = bus.rd_addr_i;
                    end else if (bus.wr_val_i) begin
                        w_wr_rdy = 1'b1;
                        w_cen    = 1'b0;
                        w_wen    = 1'b0;
                        w_addr   = bus.wr_addr_i;
                        w_dat    = bus.wr_dat_i;
                    end
                    // A winning write always clears the count, so it saturates at LIMIT.
                    if (bus.wr_val_i && !w_wr_rdy) w_starve_nxt = r_starve + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rstn) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_starve  <= '0;
            r_rd_val  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= (r_state == CLEAR) ? r_clr_cnt + ADDR_WIDTH'(1) : '0;
            r_starve  <= w_starve_nxt;
            r_rd_val  <= w_rd_gnt;
        end
    end

    assign bus.wr_rdy_o   = w_wr_rdy;
    assign bus.rd_gnt_o   = w_rd_gnt;
    assign bus.clr_done_o = w_clr_done;
    assign bus.ram_cen_o  = w_cen;
    assign bus.ram_wen_o  = w_wen;
    assign bus.ram_addr_o = w_addr;
    assign bus.ram_dat_o  = w_dat;
    assign bus.ram_oen_o  = ~r_rd_val;
    assign bus.rd_val_o   = r_rd_val;
    assign bus.rd_dat_o   = r_rd_val ? bus.ram_dat_i : '0;
endmodule
